// File: rtl/pcm_i2s_frame_sched.sv
// pcm_i2s_frame_sched: derives BCLK/WCLK from MCLK and schedules one stereo
// PCM sample per frame onto the serializer inputs, with start/stop sequencing
// and underrun muting.
module pcm_i2s_frame_sched #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  MCLK_I,
    input  logic                  RST_I,
    input  logic                  EN_I,
    input  logic [1:0]            DIV_I,
    input  logic [DATA_WIDTH-1:0] PCML_I,
    input  logic [DATA_WIDTH-1:0] PCMR_I,
    input  logic                  VALID_I,
    output logic                  READY_O,
    output logic                  BCLK_O,
    output logic                  WCLK_O,
    output logic [DATA_WIDTH-1:0] PCML_O,
    output logic [DATA_WIDTH-1:0] PCMR_O,
    output logic                  RUN_O,
    output logic                  UNDERRUN_O,
    output logic [15:0]           UNDERRUN_CNT_O
);

    localparam int unsigned F      = $clog2(2 * DATA_WIDTH);
    localparam int unsigned CNT_W  = F + 4;
    localparam int unsigned IDX_W  = $clog2(CNT_W);
    localparam int unsigned UCNT_W = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRIME = 2'd1,
        S_RUN   = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [CNT_W-1:0]    w_last;
    logic [1:0]          r_div;
    logic [1:0]          w_div_nxt;
    logic                r_stg_vld;
    logic                w_stg_vld_nxt;
    logic [DATA_WIDTH-1:0] r_stg_l;
    logic [DATA_WIDTH-1:0] r_stg_r;
    logic [DATA_WIDTH-1:0] w_stg_l_nxt;
    logic [DATA_WIDTH-1:0] w_stg_r_nxt;
    logic [DATA_WIDTH-1:0] r_pcml;
    logic [DATA_WIDTH-1:0] r_pcmr;
    logic [DATA_WIDTH-1:0] w_pcml_nxt;
    logic [DATA_WIDTH-1:0] w_pcmr_nxt;
    logic                r_ready;
    logic                w_ready_nxt;
    logic                r_bclk;
    logic                w_bclk_nxt;
    logic                r_wclk;
    logic                w_wclk_nxt;
    logic                r_run;
    logic                w_run_nxt;
    logic                r_under;
    logic                w_under_nxt;
    logic [UCNT_W-1:0]   r_ucnt;
    logic [UCNT_W-1:0]   w_ucnt_nxt;
    logic [IDX_W-1:0]    w_bidx;
    logic [IDX_W-1:0]    w_widx;
    logic                w_frame_end;
    logic                w_xfer;

    // Last counter value of a frame for the latched ratio: L-1 = 2^(div+1+F)-1.
    always_comb begin
        w_last = '0;
        case (r_div)
            2'd0:    w_last = CNT_W'((32'd1 << (F + 1)) - 32'd1);
            2'd1:    w_last = CNT_W'((32'd1 << (F + 2)) - 32'd1);
            2'd2:    w_last = CNT_W'((32'd1 << (F + 3)) - 32'd1);
            default: w_last = CNT_W'((32'd1 << (F + 4)) - 32'd1);
        endcase
    end

    assign w_frame_end = (r_cnt == w_last);

    // A transfer needs READY; dropping EN in PRIME takes priority over accepting.
    assign w_xfer = VALID_I & r_ready & ~((r_state == S_PRIME) & ~EN_I);

    // Next-state, counter, staging and output-register values.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_div_nxt     = r_div;
        w_stg_vld_nxt = r_stg_vld;
        w_stg_l_nxt   = r_stg_l;
        w_stg_r_nxt   = r_stg_r;
        w_pcml_nxt    = r_pcml;
        w_pcmr_nxt    = r_pcmr;
        w_under_nxt   = 1'b0;
        w_ucnt_nxt    = r_ucnt;
        w_run_nxt     = 1'b0;
        w_ready_nxt   = 1'b0;
        w_bidx        = '0;
        w_widx        = '0;
        w_bclk_nxt    = 1'b0;
        w_wclk_nxt    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (EN_I) begin
                    w_div_nxt   = DIV_I;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_PRIME;
                end
            end

            S_PRIME: begin
                if (!EN_I) begin
                    w_state_nxt = S_IDLE;
                end else if (w_xfer) begin
                    w_pcml_nxt  = PCML_I;
                    w_pcmr_nxt  = PCMR_I;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_RUN;
                end
            end

            S_RUN, S_STOP: begin
                w_cnt_nxt = w_frame_end ? '0 : r_cnt + 1'b1;
                if (w_frame_end) begin
                    // New frame data becomes visible together with the WCLK fall.
                    if (r_stg_vld) begin
                        w_pcml_nxt    = r_stg_l;
                        w_pcmr_nxt    = r_stg_r;
                        w_stg_vld_nxt = 1'b0;
                    end else if (w_xfer) begin
                        w_pcml_nxt = PCML_I;
                        w_pcmr_nxt = PCMR_I;
                    end else begin
                        w_pcml_nxt  = '0;
                        w_pcmr_nxt  = '0;
                        w_under_nxt = 1'b1;
                        if (r_ucnt != '1) begin
                            w_ucnt_nxt = r_ucnt + 1'b1;
                        end
                    end
                end else if (w_xfer) begin
                    w_stg_l_nxt   = PCML_I;
                    w_stg_r_nxt   = PCMR_I;
                    w_stg_vld_nxt = 1'b1;
                end

                if (r_state == S_RUN) begin
                    if (!EN_I) begin
                        w_state_nxt = S_STOP;
                    end
                end else if (w_frame_end) begin
                    w_state_nxt   = S_IDLE;
                    w_cnt_nxt     = '0;
                    w_stg_vld_nxt = 1'b0;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Status and clock outputs are registered copies of next-cycle state.
        w_run_nxt   = (w_state_nxt == S_RUN) || (w_state_nxt == S_STOP);
        w_ready_nxt = ((w_state_nxt == S_PRIME) || (w_state_nxt == S_RUN)) && !w_stg_vld_nxt;
        w_bidx      = IDX_W'(w_div_nxt);
        w_widx      = IDX_W'(w_div_nxt) + IDX_W'(F);
        w_bclk_nxt  = w_run_nxt & w_cnt_nxt[w_bidx];
        w_wclk_nxt  = w_run_nxt & w_cnt_nxt[w_widx];
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge MCLK_I) begin
        if (RST_I) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_div     <= '0;
            r_stg_vld <= 1'b0;
            r_stg_l   <= '0;
            r_stg_r   <= '0;
            r_pcml    <= '0;
            r_pcmr    <= '0;
            r_ready   <= 1'b0;
            r_bclk    <= 1'b0;
            r_wclk    <= 1'b0;
            r_run     <= 1'b0;
            r_under   <= 1'b0;
            r_ucnt    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_div     <= w_div_nxt;
            r_stg_vld <= w_stg_vld_nxt;
            r_stg_l   <= w_stg_l_nxt;
            r_stg_r   <= w_stg_r_nxt;
            r_pcml    <= w_pcml_nxt;
            r_pcmr    <= w_pcmr_nxt;
            r_ready   <= w_ready_nxt;
            r_bclk    <= w_bclk_nxt;
            r_wclk    <= w_wclk_nxt;
            r_run     <= w_run_nxt;
            r_under   <= w_under_nxt;
            r_ucnt    <= w_ucnt_nxt;
        end
    end

    assign READY_O        = r_ready;
    assign BCLK_O         = r_bclk;
    assign WCLK_O         = r_wclk;
    assign PCML_O         = r_pcml;
    assign PCMR_O         = r_pcmr;
    assign RUN_O          = r_run;
    assign UNDERRUN_O     = r_under;
    assign UNDERRUN_CNT_O = r_ucnt;

endmodule
